me_dcache_seq: RTL and testbench
================================

Name: me_dcache_seq

Overview:
- Memory-stage access sequencer that drives the data-memory port for scalar word loads/stores and 4x4 matrix loads/stores.
- A matrix access is sequenced as 16 single-word transactions.
- Sits between the EX/ME pipeline register and the data memory.
- Exports the 6-bit one-hot state that ME stage control uses to gate its ready: ME ready requires state == FREE.

Parameters:
- MAT_DIM, 4, matrix rows/columns. The element count is MAT_DIM*MAT_DIM, and the port widths below assume 4.
- ELEM_BYTES, 4, byte size of one matrix element. It is the column stride in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  EX has a memory op. It is accepted in any cycle where req_valid=1 and state==FREE.
- req_op  in  2  00 scalar load, 01 scalar store, 10 matrix load, 11 matrix store
- req_addr  in  32  base byte address
- req_stride  in  32  matrix row stride in bytes
- req_wdata  in  32  scalar store data
- req_wmat  in  512  matrix store data; element (i,j) is at bits [(i*4+j)*32 +: 32]
- state  out  6  one-hot: FREE=000001, S_REQ=000010, S_WAIT=000100, M_REQ=001000, M_WAIT=010000, DONE=100000
- mem_req  out  1  memory request valid
- mem_we  out  1  write enable
- mem_addr  out  32  word address (byte address)
- mem_wdata  out  32  write data
- mem_gnt  in  1  memory accepts a request this cycle
- mem_rvalid  in  1  response/ack: read data is valid, or the write has completed
- mem_rdata  in  32  read data
- done  out  1  result valid to WB
- wb_ready  in  1  WB consumes the result
- res_R  out  32  scalar load result
- res_M  out  512  matrix load result, same layout as req_wmat
- err  out  1  misaligned access, qualified by done

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE; mem_req=0, mem_we=0, done=0, err=0.
  - mem_addr, mem_wdata, res_R, res_M and the element counter k are all 0.
  - Reset mid-transaction abandons the access immediately, with no completion. Any later mem_rvalid is ignored while state is FREE.
- FREE:
  - On accept, latch op, addr, stride, wdata and wmat, and clear k.
  - If req_addr[1:0]!=0, go to DONE with err=1 and make no memory access. This applies to both scalar and matrix ops.
  - Otherwise a scalar op goes to S_REQ and a matrix op goes to M_REQ.
- S_REQ:
  - mem_req=1, mem_addr=addr, mem_we=op[0], mem_wdata=wdata.
  - Hold all request signals stable until mem_gnt=1, then go to S_WAIT.
- S_WAIT:
  - mem_req=0. On mem_rvalid, a load captures res_R=mem_rdata. Then go to DONE.
- M_REQ:
  - i=k[3:2], j=k[1:0].
  - mem_addr = addr + i*stride + j*ELEM_BYTES, modulo 2^32 (wraps, no error).
  - mem_we=op[0]; mem_wdata = element k of wmat.
  - Hold stable until mem_gnt, then go to M_WAIT.
- M_WAIT:
  - On mem_rvalid, a load writes res_M element k = mem_rdata.
  - If k==15, go to DONE; otherwise k=k+1 and return to M_REQ.
  - There is exactly one outstanding transaction, and no back-to-back issue in the same cycle as rvalid.
- DONE:
  - done=1; err holds its value.
  - On wb_ready=1, go to FREE with done=0 and err=0.
  - A new request cannot be accepted in the same cycle as leaving DONE. It is accepted next cycle at the earliest.
- Data outputs:
  - res_R and res_M hold their last values until overwritten.
  - A store leaves them unchanged.
- Latency with zero-wait memory (gnt in the S_REQ/M_REQ cycle, rvalid the next cycle):
  - Scalar: accept to done = 3 cycles.
  - Matrix: 1 + 16*2 = 33 cycles.
- Robustness:
  - mem_gnt outside S_REQ/M_REQ is ignored.
  - mem_rvalid outside S_WAIT/M_WAIT is ignored.
  - req_valid while not FREE is ignored (not latched).
- state is registered and always exactly one-hot.

Test Plan:
- Scalar load: addr=0x100, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> res_R=0xDEADBEEF; done rises 3 cycles after accept; state sequence FREE,S_REQ,S_WAIT,DONE.
- Scalar store with gnt stalled 4 cycles: addr=0x200, wdata=0x12345678 -> mem_req/addr/wdata/we stay stable for all 5 S_REQ cycles; done after rvalid; res_R unchanged.
- Matrix load: base=0x1000, stride=0x40, memory returns rdata = the address -> 16 addresses in the order 0x1000,0x1004,0x1008,0x100C,0x1040,...,0x10CC; res_M element(2,3)=0x108C; done at cycle 33.
- Matrix store with wrap: base=0xFFFFFFF0, stride=0x10 -> element (1,0) address 0x00000000 and element (3,3) address 0x0000002C; each mem_wdata equals the corresponding wmat element.
- Misaligned: scalar load at 0x102 -> no mem_req; done and err=1 in the cycle after accept; err clears when wb_ready is taken. Also hold wb_ready=0 for 3 cycles and check done stays 1 and a new req_valid is not accepted.
- Async reset asserted in M_WAIT at k=7 -> state=FREE and mem_req=0 immediately, without waiting for a clock edge; a late rvalid is ignored; the next matrix load restarts at k=0.

Source files
------------

// File: rtl/me_dcache_seq_if.sv
// Single-word data-memory port between the ME access sequencer and data memory.
// One request in flight; rvalid acknowledges both read data and write completion.
interface me_dcache_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/me_dcache_seq.sv
// ME-stage access sequencer: scalar word loads/stores and MAT_DIM x MAT_DIM matrix
// loads/stores, the latter issued as one single-word transaction per element.
module me_dcache_seq #(
  parameter int MAT_DIM    = 4,
  parameter int ELEM_BYTES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  input  logic [1:0]                            req_op,
  input  logic [31:0]                           req_addr,
  input  logic [31:0]                           req_stride,
  input  logic [31:0]                           req_wdata,
  input  logic [MAT_DIM*MAT_DIM-1:0][31:0]      req_wmat,
  output logic [5:0]                            state,
  me_dcache_seq_if.master                       mem,
  output logic                                  done,
  input  logic                                  wb_ready,
  output logic [31:0]                           res_R,
  output logic [MAT_DIM*MAT_DIM-1:0][31:0]      res_M,
  output logic                                  err
);
  localparam int NELEM = MAT_DIM * MAT_DIM;
  localparam int KW    = $clog2(NELEM);
  localparam int JW    = $clog2(MAT_DIM);

  typedef enum logic [5:0] {
    FREE   = 6'b000001,
    S_REQ  = 6'b000010,
    S_WAIT = 6'b000100,
    M_REQ  = 6'b001000,
    M_WAIT = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t                  st_q, st_d;
  logic                    we_q;
  logic [31:0]             addr_q, stride_q, wdata_q;
  logic [NELEM-1:0][31:0]  wmat_q;
  logic [KW-1:0]           k_q;
  logic                    err_q;
  logic                    accept, misal, k_last;
  logic [31:0]             m_addr;

  assign accept = (st_q == FREE) && req_valid;
  assign misal  = (req_addr[1:0] != 2'b00);
  assign k_last = (k_q == KW'(NELEM - 1));

  // Row index is the upper counter bits, column index the lower; sum wraps mod 2^32.
  assign m_addr = addr_q + 32'(k_q[KW-1:JW]) * stride_q
                + 32'(k_q[JW-1:0]) * 32'(ELEM_BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= FREE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d          = st_q;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (st_q)
      FREE:   if (req_valid) st_d = misal ? DONE : (req_op[1] ? M_REQ : S_REQ);
      S_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        if (mem.mem_gnt) st_d = S_WAIT;
      end
      S_WAIT: if (mem.mem_rvalid) st_d = DONE;
      M_REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = m_addr;
        mem.mem_wdata = wmat_q[k_q];
        if (mem.mem_gnt) st_d = M_WAIT;
      end
      M_WAIT: if (mem.mem_rvalid) st_d = k_last ? DONE : M_REQ;
      DONE:   if (wb_ready) st_d = FREE;
      default: st_d = FREE;
    endcase
  end

  assign state = st_q;
  assign done  = (st_q == DONE);
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      wdata_q  <= '0;
      wmat_q   <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      res_R    <= '0;
      res_M    <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_op[0];
        addr_q   <= req_addr;
        stride_q <= req_stride;
        wdata_q  <= req_wdata;
        wmat_q   <= req_wmat;
        k_q      <= '0;
        err_q    <= misal;
      end
      if (st_q == S_WAIT && mem.mem_rvalid && !we_q) res_R <= mem.mem_rdata;
      if (st_q == M_WAIT && mem.mem_rvalid) begin
        if (!we_q)   res_M[k_q] <= mem.mem_rdata;
        if (!k_last) k_q <= k_q + KW'(1);
      end
      if (st_q == DONE && wb_ready) err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_me_dcache_seq.sv
// Bench for me_dcache_seq: a responding memory model checks every granted request
// against a queue of expected transactions; scenario tasks check results and timing.
module tb_me_dcache_seq;
  localparam logic [5:0] ST_FREE = 6'b000001, ST_SREQ = 6'b000010, ST_SWAIT = 6'b000100,
                         ST_MREQ = 6'b001000, ST_MWAIT = 6'b010000, ST_DONE = 6'b100000;

  logic         clk = 1'b0, rst = 1'b0;
  logic         req_valid = 1'b0;
  logic [1:0]   req_op = '0;
  logic [31:0]  req_addr = '0, req_stride = '0, req_wdata = '0;
  logic [511:0] req_wmat = '0;
  logic [5:0]   state;
  logic         done, err;
  logic         wb_ready = 1'b0;
  logic [31:0]  res_R;
  logic [511:0] res_M;

  me_dcache_seq_if mif();

  me_dcache_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_stride(req_stride), .req_wdata(req_wdata), .req_wmat(req_wmat), .state(state),
    .mem(mif), .done(done), .wb_ready(wb_ready), .res_R(res_R), .res_M(res_M), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mtx_t;
  mtx_t        exp_q[$];
  logic [31:0] log_q[$];
  logic [5:0]  st_log[$];
  int checks = 0, errors = 0;

  // memory model controls
  int          gnt_delay = 0, grant_cnt = 0, req_cyc = 0, stall = 0;
  bit          rd_mode = 1'b0, mem_auto = 1'b1, pend = 1'b0;
  logic [31:0] rd_val = '0, pend_data = '0, man_rdata = '0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  mtx_t        e;

  initial begin
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_auto) begin
        mif.mem_gnt = man_gnt; mif.mem_rvalid = man_rvalid; mif.mem_rdata = man_rdata;
      end else begin
        mif.mem_rvalid = pend;
        mif.mem_rdata  = pend ? pend_data : 32'h0;
        pend = 1'b0;
        mif.mem_gnt = 1'b0;
        if (!rst) stall = 0;
        else if (mif.mem_req === 1'b1) begin
          req_cyc++;
          if (stall == 0) begin
            h_we = mif.mem_we; h_addr = mif.mem_addr; h_wdata = mif.mem_wdata;
          end else begin
            checks++;
            if (mif.mem_we !== h_we || mif.mem_addr !== h_addr || mif.mem_wdata !== h_wdata) begin
              errors++;
              $display("FAIL req_hold: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                       mif.mem_we, mif.mem_addr, mif.mem_wdata, h_we, h_addr, h_wdata);
            end
          end
          if (stall >= gnt_delay) begin
            mif.mem_gnt = 1'b1;
            stall = 0;
            grant_cnt++;
            log_q.push_back(mif.mem_addr);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_req: got addr=%h we=%b, required no request", mif.mem_addr, mif.mem_we);
            end else begin
              e = exp_q.pop_front();
              if (mif.mem_addr !== e.addr || mif.mem_we !== e.we || (e.we && mif.mem_wdata !== e.wdata)) begin
                errors++;
                $display("FAIL mem_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                         mif.mem_we, mif.mem_addr, mif.mem_wdata, e.we, e.addr, e.wdata);
              end
            end
            pend = 1'b1;
            pend_data = rd_mode ? mif.mem_addr : rd_val;
          end else stall++;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, stride, wdata,
                       input logic [511:0] wmat);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_stride = stride;
    req_wdata = wdata; req_wmat = wmat;
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  // lat counts cycles from the accept cycle to the first cycle with done=1
  task automatic wait_done(output int lat);
    lat = 1;
    st_log.delete();
    while (done !== 1'b1 && lat < 200) begin
      st_log.push_back(state);
      @(posedge clk); #2;
      lat++;
    end
    st_log.push_back(state);
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic release_wb();
    wb_ready = 1'b1;
    @(posedge clk); #2;
    wb_ready = 1'b0;
  endtask

  task automatic push_mat(input logic we, input logic [31:0] base, stride, input logic [511:0] wmat);
    for (int k = 0; k < 16; k++)
      exp_q.push_back('{we, base + 32'(k / 4) * stride + 32'(k % 4) * 32'd4, wmat[k*32 +: 32]});
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (state !== ST_FREE || mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got state=%b req=%b we=%b done=%b err=%b, required 000001 0 0 0 0",
               state, mif.mem_req, mif.mem_we, done, err);
    end
    checks++;
    if (mif.mem_addr !== 32'h0 || mif.mem_wdata !== 32'h0 || res_R !== 32'h0 || res_M !== 512'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h res_R=%h res_M!=0:%b, required all zero",
               mif.mem_addr, mif.mem_wdata, res_R, res_M != 512'h0);
    end
    @(posedge clk); #2; rst = 1'b1;
    // stray gnt/rvalid while FREE must change nothing
    mem_auto = 1'b0; man_gnt = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0;
    repeat (2) begin @(posedge clk); #2; end
    man_gnt = 1'b0; man_rvalid = 1'b0;
    @(posedge clk); #2; mem_auto = 1'b1;
    checks++;
    if (state !== ST_FREE || res_R !== 32'h0 || res_M !== 512'h0) begin
      errors++;
      $display("FAIL stray_free: got state=%b res_R=%h, required 000001 00000000", state, res_R);
    end
  endtask

  task automatic test_scalar_load();
    int lat;
    gnt_delay = 0; rd_mode = 1'b0; rd_val = 32'hDEADBEEF;
    exp_q.push_back('{1'b0, 32'h100, 32'h0});
    checks++;
    if (state !== ST_FREE) begin
      errors++; $display("FAIL sl_idle: got state=%b, required %b", state, ST_FREE);
    end
    issue(2'b00, 32'h100, 32'h0, 32'h0, '0);
    wait_done(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL sl_latency: got %0d, required 3", lat); end
    checks++;
    if (st_log.size() != 3 || st_log[0] !== ST_SREQ || st_log[1] !== ST_SWAIT || st_log[2] !== ST_DONE) begin
      errors++;
      $display("FAIL sl_states: got %0d states first=%b, required S_REQ,S_WAIT,DONE", st_log.size(), st_log.size() > 0 ? st_log[0] : 6'h0);
    end
    checks++;
    if (res_R !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL sl_result: got res_R=%h err=%b, required deadbeef 0", res_R, err);
    end
    release_wb();
    checks++;
    if (state !== ST_FREE || done !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL sl_release: got state=%b done=%b pending=%0d, required 000001 0 0", state, done, exp_q.size());
    end
  endtask

  task automatic test_store_stall();
    int lat;
    gnt_delay = 4; req_cyc = 0;
    exp_q.push_back('{1'b1, 32'h200, 32'h12345678});
    issue(2'b01, 32'h200, 32'h0, 32'h12345678, '0);
    wait_done(lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL ss_latency: got %0d, required 7", lat); end
    checks++;
    if (req_cyc != 5) begin errors++; $display("FAIL ss_req_cycles: got %0d, required 5", req_cyc); end
    checks++;
    if (res_R !== 32'hDEADBEEF || err !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL ss_result: got res_R=%h err=%b pending=%0d, required deadbeef 0 0", res_R, err, exp_q.size());
    end
    release_wb();
    gnt_delay = 0;
  endtask

  task automatic test_matrix_load();
    int lat;
    bit bad = 1'b0;
    rd_mode = 1'b1;
    push_mat(1'b0, 32'h1000, 32'h40, '0);
    issue(2'b10, 32'h1000, 32'h40, 32'h0, '0);
    wait_done(lat);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL ml_latency: got %0d, required 33", lat); end
    checks++;
    if (res_M[(2*4+3)*32 +: 32] !== 32'h108C) begin
      errors++; $display("FAIL ml_elem23: got %h, required 0000108c", res_M[(2*4+3)*32 +: 32]);
    end
    for (int k = 0; k < 16; k++)
      if (res_M[k*32 +: 32] !== 32'h1000 + 32'(k / 4) * 32'h40 + 32'(k % 4) * 32'd4) bad = 1'b1;
    checks++;
    if (bad || exp_q.size() != 0) begin
      errors++; $display("FAIL ml_all: got element mismatch=%b pending=%0d, required 0 0", bad, exp_q.size());
    end
    release_wb();
  endtask

  task automatic test_matrix_store_wrap();
    int lat;
    logic [511:0] wm, prev;
    for (int k = 0; k < 16; k++) wm[k*32 +: 32] = $urandom;
    prev = res_M;
    log_q.delete();
    push_mat(1'b1, 32'hFFFFFFF0, 32'h10, wm);
    issue(2'b11, 32'hFFFFFFF0, 32'h10, 32'h0, wm);
    wait_done(lat);
    checks++;
    if (lat != 33 || exp_q.size() != 0) begin
      errors++; $display("FAIL ms_latency: got %0d pending=%0d, required 33 0", lat, exp_q.size());
    end
    checks++;
    if (log_q.size() != 16 || log_q[4] !== 32'h0 || log_q[15] !== 32'h2C) begin
      errors++;
      $display("FAIL ms_wrap: got n=%0d e10=%h e33=%h, required 16 00000000 0000002c",
               log_q.size(), log_q.size() > 4 ? log_q[4] : 32'hX, log_q.size() > 15 ? log_q[15] : 32'hX);
    end
    checks++;
    if (res_M !== prev || err !== 1'b0) begin
      errors++; $display("FAIL ms_res_kept: got res_M changed=%b err=%b, required 0 0", res_M !== prev, err);
    end
    release_wb();
  endtask

  task automatic test_misaligned();
    int lat;
    issue(2'b00, 32'h102, 32'h0, 32'h0, '0);
    wait_done(lat);
    checks++;
    if (lat != 1 || err !== 1'b1) begin
      errors++; $display("FAIL mis_done: got lat=%0d err=%b, required 1 1", lat, err);
    end
    // a request offered while DONE must not be taken, nor in the cycle that leaves DONE
    req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h300;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || state !== ST_DONE) begin
        errors++; $display("FAIL mis_hold: got done=%b err=%b state=%b, required 1 1 100000", done, err, state);
      end
    end
    wb_ready = 1'b1;
    @(posedge clk); #2;
    wb_ready = 1'b0;
    checks++;
    if (state !== ST_FREE || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL mis_release: got state=%b done=%b err=%b, required 000001 0 0", state, done, err);
    end
    rd_mode = 1'b0; rd_val = 32'h55AA55AA;
    exp_q.push_back('{1'b0, 32'h300, 32'h0});
    @(posedge clk); #2;
    req_valid = 1'b0;
    checks++;
    if (state !== ST_SREQ) begin errors++; $display("FAIL mis_next_accept: got %b, required %b", state, ST_SREQ); end
    wait_done(lat);
    checks++;
    if (lat != 3 || res_R !== 32'h55AA55AA || err !== 1'b0) begin
      errors++; $display("FAIL mis_followup: got lat=%0d res_R=%h err=%b, required 3 55aa55aa 0", lat, res_R, err);
    end
    release_wb();
  endtask

  task automatic test_reset_midflight();
    int lat, cyc = 0;
    rd_mode = 1'b1; grant_cnt = 0;
    push_mat(1'b0, 32'h3000, 32'h10, '0);
    issue(2'b10, 32'h3000, 32'h10, 32'h0, '0);
    while (grant_cnt < 8 && cyc < 100) begin @(posedge clk); #2; cyc++; end
    @(posedge clk); #2;
    checks++;
    if (state !== ST_MWAIT || grant_cnt != 8) begin
      errors++; $display("FAIL rst_setup: got state=%b grants=%0d, required 010000 8", state, grant_cnt);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (state !== ST_FREE || mif.mem_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_async: got state=%b req=%b done=%b, required 000001 0 0", state, mif.mem_req, done);
    end
    mem_auto = 1'b0; exp_q.delete();
    man_rvalid = 1'b1; man_rdata = 32'hBADBAD00;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    man_rvalid = 1'b0;
    checks++;
    if (state !== ST_FREE || res_M !== 512'h0) begin
      errors++; $display("FAIL rst_late_rvalid: got state=%b res_M changed=%b, required 000001 0", state, res_M !== 512'h0);
    end
    @(posedge clk); #2;
    mem_auto = 1'b1;
    push_mat(1'b0, 32'h2000, 32'h20, '0);
    issue(2'b10, 32'h2000, 32'h20, 32'h0, '0);
    wait_done(lat);
    checks++;
    if (lat != 33 || exp_q.size() != 0 || res_M[31:0] !== 32'h2000) begin
      errors++; $display("FAIL rst_restart: got lat=%0d pending=%0d e00=%h, required 33 0 00002000", lat, exp_q.size(), res_M[31:0]);
    end
    release_wb();
  endtask

  initial begin
    test_reset();
    test_scalar_load();
    test_store_stall();
    test_matrix_load();
    test_matrix_store_wrap();
    test_misaligned();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end
endmodule
